// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR pseudo-random source, plus a width-generic
// single-step function used as a reference for the sequence.
package lfsr_pkg;

  localparam bit MODE_FIB    = 1'b0;
  localparam bit MODE_GALOIS = 1'b1;

  localparam logic [31:0] DEFAULT_TAPS32 = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED32 = 32'h2048FAFA;

  // One LFSR step on the low 'width' bits of state (width 4..64).
  function automatic logic [63:0] lfsr_step(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input bit          mode,
                                            input int          width);
    logic [63:0] mask;
    logic [63:0] s;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    s    = state & mask;
    if (mode == MODE_FIB)
      lfsr_step = ((s << 1) | {63'd0, ^(s & taps)}) & mask;
    else
      lfsr_step = ((s << 1) & mask) ^ (s[width-1] ? (taps & mask) : 64'd0);
  endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// A single combinational LFSR step in either Fibonacci or Galois form.
module lfsr_step_comb
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS32,
  parameter bit               MODE  = MODE_FIB
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_next
);

  // Fibonacci folds the tapped bits into bit0; Galois XORs the taps in when the msb falls out.
  always_comb begin
    if (MODE == MODE_FIB)
      state_next = {state_in[WIDTH-2:0], ^(state_in & TAPS)};
    else
      state_next = {state_in[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_in[WIDTH-1]}} & TAPS);
  end

endmodule

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random word source: STEPS chained steps per enabled cycle,
// seed load with zero-lockup recovery, valid/ready output of fully fresh words.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS32,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED32,
  parameter bit               MODE  = MODE_FIB,
  parameter int               STEPS = 1,
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] state_out,
  output logic             lockup
);

  localparam int              CW      = $clog2(OUT_W + 1);
  localparam logic [CW-1:0]   STEPS_C = CW'(STEPS);
  localparam logic [CW-1:0]   FULL_C  = CW'(OUT_W);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] chain [STEPS+1];
  logic [WIDTH-1:0] stepped;
  logic [CW-1:0]    fresh_cnt;
  logic [CW-1:0]    fresh_next;
  logic [CW:0]      fresh_sum;
  logic             take;

  assign chain[0] = state;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_step_comb #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
    ) u_step (
      .state_in   (chain[g]),
      .state_next (chain[g+1])
    );
  end

  assign stepped   = chain[STEPS];
  assign take      = out_valid & out_ready;
  assign out_data  = state[OUT_W-1:0];
  assign state_out = state;

  // Fresh-bit count: load clears it, a take restarts it (keeping this cycle's steps), else saturating add.
  always_comb begin
    fresh_sum  = {1'b0, fresh_cnt} + {1'b0, STEPS_C};
    fresh_next = fresh_cnt;
    if (load_enable)
      fresh_next = '0;
    else if (take)
      fresh_next = enable ? STEPS_C : '0;
    else if (enable)
      fresh_next = (fresh_sum >= {1'b0, FULL_C}) ? FULL_C : fresh_sum[CW-1:0];
  end

  // State register with load/zero recovery, registered valid flag and lockup pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      fresh_cnt <= '0;
      out_valid <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      lockup    <= 1'b0;
      fresh_cnt <= fresh_next;
      out_valid <= (fresh_next == FULL_C);
      if (load_enable) begin
        if (load_value == '0) begin
          state  <= SEED;
          lockup <= 1'b1;
        end else begin
          state <= load_value;
        end
      end else if (enable) begin
        // A zero state would freeze the generator; substitute the seed instead.
        if (stepped == '0) begin
          state  <= SEED;
          lockup <= 1'b1;
        end else begin
          state <= stepped;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: four configurations driven in lockstep, a reference
// model built on lfsr_pkg::lfsr_step, and a scoreboard for taken words.
module tb_lfsr_prng;
  import lfsr_pkg::*;

  localparam int N = 4;
  localparam int          W_A     [N] = '{32, 32, 32, 8};
  localparam int          STEPS_A [N] = '{1, 4, 3, 1};
  localparam int          OW_A    [N] = '{8, 8, 8, 4};
  localparam bit          MODE_A  [N] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [63:0] TAPS_A  [N] = '{64'h80200003, 64'h80200003, 64'h80200003, 64'h0};
  localparam logic [63:0] SEED_A  [N] = '{64'h2048FAFA, 64'h2048FAFA, 64'h2048FAFA, 64'h01};

  logic        clk = 1'b0;
  logic        rst, enable, load_enable, out_ready;
  logic [31:0] load_value;

  always #5 clk = ~clk;

  logic [7:0]  o_data0, o_data1, o_data2;
  logic [3:0]  o_data3;
  logic [31:0] o_state0, o_state1, o_state2;
  logic [7:0]  o_state3;
  logic        o_valid0, o_valid1, o_valid2, o_valid3;
  logic        o_lock0, o_lock1, o_lock2, o_lock3;

  lfsr_prng u0 (.clk(clk), .rst(rst), .enable(enable), .load_enable(load_enable),
    .load_value(load_value), .out_data(o_data0), .out_valid(o_valid0),
    .out_ready(out_ready), .state_out(o_state0), .lockup(o_lock0));

  lfsr_prng #(.STEPS(4)) u1 (.clk(clk), .rst(rst), .enable(enable),
    .load_enable(load_enable), .load_value(load_value), .out_data(o_data1),
    .out_valid(o_valid1), .out_ready(out_ready), .state_out(o_state1), .lockup(o_lock1));

  lfsr_prng #(.MODE(MODE_GALOIS), .STEPS(3)) u2 (.clk(clk), .rst(rst), .enable(enable),
    .load_enable(load_enable), .load_value(load_value), .out_data(o_data2),
    .out_valid(o_valid2), .out_ready(out_ready), .state_out(o_state2), .lockup(o_lock2));

  lfsr_prng #(.WIDTH(8), .TAPS(8'h00), .SEED(8'h01), .MODE(MODE_GALOIS), .STEPS(1), .OUT_W(4))
    u3 (.clk(clk), .rst(rst), .enable(enable), .load_enable(load_enable),
    .load_value(load_value[7:0]), .out_data(o_data3), .out_valid(o_valid3),
    .out_ready(out_ready), .state_out(o_state3), .lockup(o_lock3));

  logic [63:0] d_state [N];
  logic [63:0] d_data  [N];
  logic        d_valid [N];
  logic        d_lock  [N];

  assign d_state[0] = 64'(o_state0);
  assign d_state[1] = 64'(o_state1);
  assign d_state[2] = 64'(o_state2);
  assign d_state[3] = 64'(o_state3);
  assign d_data[0]  = 64'(o_data0);
  assign d_data[1]  = 64'(o_data1);
  assign d_data[2]  = 64'(o_data2);
  assign d_data[3]  = 64'(o_data3);
  assign d_valid[0] = o_valid0;
  assign d_valid[1] = o_valid1;
  assign d_valid[2] = o_valid2;
  assign d_valid[3] = o_valid3;
  assign d_lock[0]  = o_lock0;
  assign d_lock[1]  = o_lock1;
  assign d_lock[2]  = o_lock2;
  assign d_lock[3]  = o_lock3;

  typedef struct {
    int          inst;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] m_state [N];
  int          m_fresh [N];
  logic        m_lock  [N];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [63:0] wmask(input int i);
    return (64'd1 << W_A[i]) - 64'd1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d got %0h expected %0h", name, inst, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = SEED_A[i];
      m_fresh[i] = 0;
      m_lock[i]  = 1'b0;
    end
  endtask

  task automatic model_update(input logic en, input logic ld, input logic [31:0] v, input logic rdy);
    logic [63:0] s;
    logic        tk;
    for (int i = 0; i < N; i++) begin
      tk        = (m_fresh[i] == OW_A[i]) && rdy;
      m_lock[i] = 1'b0;
      if (ld) begin
        s = 64'(v) & wmask(i);
        if (s == 64'd0) begin
          m_state[i] = SEED_A[i];
          m_lock[i]  = 1'b1;
        end else begin
          m_state[i] = s;
        end
        m_fresh[i] = 0;
      end else begin
        if (en) begin
          s = m_state[i];
          for (int k = 0; k < STEPS_A[i]; k++) s = lfsr_step(s, TAPS_A[i], MODE_A[i], W_A[i]);
          if (s == 64'd0) begin
            s         = SEED_A[i];
            m_lock[i] = 1'b1;
          end
          m_state[i] = s;
        end
        if (tk)
          m_fresh[i] = en ? STEPS_A[i] : 0;
        else if (en)
          m_fresh[i] = imin(m_fresh[i] + STEPS_A[i], OW_A[i]);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("state", i, d_state[i], m_state[i]);
      chk("valid", i, 64'(d_valid[i]), 64'(m_fresh[i] == OW_A[i]));
      chk("lockup", i, 64'(d_lock[i]), 64'(m_lock[i]));
    end
    chk("galois_nonzero", 2, 64'(d_state[2] != 64'd0), 64'd1);
  endtask

  // One clock: drive inputs, queue expected words for takes, check, then advance the model.
  task automatic cycle(input logic r, input logic en, input logic ld, input logic [31:0] v, input logic rdy);
    exp_t e;
    rst         = r;
    enable      = en;
    load_enable = ld;
    load_value  = v;
    out_ready   = rdy;
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        if ((m_fresh[i] == OW_A[i]) && rdy) begin
          e.inst = i;
          e.data = m_state[i] & ((64'd1 << OW_A[i]) - 64'd1);
          sb.push_back(e);
        end
      end
    end
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_update(en, ld, v, rdy);
  endtask

  task automatic count_to_valid(input string name);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk(name, 0, 64'(d_valid[0]), 64'(k == 8));
    end
  endtask

  // Scoreboard monitor: every take presented by a DUT consumes the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < N; i++) begin
        if (d_valid[i] && out_ready) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL take_unexpected inst%0d got data %0h expected no take", i, d_data[i]);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.inst != i || mon_e.data !== d_data[i]) begin
              fails++;
              $display("FAIL take_data inst%0d got %0h expected inst%0d %0h",
                       i, d_data[i], mon_e.inst, mon_e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; load_enable = 1'b0; load_value = 32'h0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    chk("reset_state", 0, d_state[0], 64'h2048FAFA);
    chk("reset_valid", 0, 64'(d_valid[0]), 64'd0);
    chk("reset_lockup", 0, 64'(d_lock[0]), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("first_step", 0, d_state[0], 64'h4091F5F5);

    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    count_to_valid("valid_after_8");
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("valid_held", 0, 64'(d_valid[0]), 64'd1);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("valid_drop_on_take", 0, 64'(d_valid[0]), 64'd0);
    count_to_valid("valid_again_8");

    cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("load0_state", 0, d_state[0], 64'h2048FAFA);
    chk("load0_lockup", 0, 64'(d_lock[0]), 64'd1);
    chk("load0_valid", 0, 64'(d_valid[0]), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lockup_one_cycle", 0, 64'(d_lock[0]), 64'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h1, 1'b0);
    chk("load_beats_enable", 0, d_state[0], 64'h1);
    chk("load_beats_enable", 1, d_state[1], 64'h1);

    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("steps4_not_valid", 1, 64'(d_valid[1]), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("steps4_valid_2", 1, 64'(d_valid[1]), 64'd1);

    cycle(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("fresh7_not_valid", 0, 64'(d_valid[0]), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("midword_reset_state", 0, d_state[0], 64'h2048FAFA);
    chk("midword_reset_valid", 0, 64'(d_valid[0]), 64'd0);
    count_to_valid("restart_after_reset");

    for (int n = 0; n < 10000; n++) begin
      cycle(1'($urandom_range(0, 499) == 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk("scoreboard_drained", 0, 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
